// File: rtl/mem_pkg.sv
// Shared types and grant encodings for the ssram port arbiter.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } arb_state_t;

    typedef struct packed {
        logic [31:0] address;
        logic        read_enable;
        logic        write_enable;
        logic [3:0]  write_byte_enable;
        logic [31:0] write_data;
    } mem_req_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating up-counter with synchronous clear; o_hit is high while the count sits at LIMIT.
module mem_arb_timer #(
    parameter int LIMIT = 4,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != W'(LIMIT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_hit = (r_count == W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester ssram arbiter: data port has priority, fetch port is protected by a
// starvation limit, and a watchdog self-completes accesses that never get an ack.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_address,
    input  logic        i_read_enable,
    output logic [31:0] i_read_data,
    output logic        i_read_ack,
    input  logic [31:0] d_address,
    input  logic        d_read_enable,
    output logic [31:0] d_read_data,
    output logic        d_read_ack,
    input  logic        d_write_enable,
    input  logic [3:0]  d_write_byte_enable,
    input  logic [31:0] d_write_data,
    output logic        d_write_ack,
    output logic [31:0] address,
    output logic        read_enable,
    input  logic [31:0] read_data,
    input  logic        read_ack,
    output logic        write_enable,
    output logic [3:0]  write_byte_enable,
    output logic [31:0] write_data,
    input  logic        write_ack,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    arb_state_t r_state;
    logic       r_timeout_err;
    mem_req_t   w_req;
    logic       w_idle, w_busy_i, w_busy_d;
    logic       w_grant_d, w_grant_i;
    logic       w_starve_hit, w_starve_clr, w_starve_inc;
    logic       w_wd_hit, w_wd_expire;
    logic       w_mem_ack, w_withdraw, w_owner_ack;

    assign w_idle   = (r_state == IDLE);
    assign w_busy_i = (r_state == BUSY_I);
    assign w_busy_d = (r_state == BUSY_D);

    assign w_grant_d = w_idle && (d_read_enable || d_write_enable)
                       && (!i_read_enable || !w_starve_hit);
    assign w_grant_i = w_idle && !w_grant_d && i_read_enable;

    assign w_starve_inc = w_grant_d && i_read_enable;
    assign w_starve_clr = w_grant_i || (w_idle && !i_read_enable);

    mem_arb_timer #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_starve_clr),
        .i_en  (w_starve_inc),
        .o_hit (w_starve_hit)
    );

    // Busy cycle k sees count k-1, so the hit lands in exactly the TIMEOUT-th busy cycle.
    mem_arb_timer #(.LIMIT(TIMEOUT - 1)) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_idle),
        .i_en  (!w_idle),
        .o_hit (w_wd_hit)
    );

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_req = '0;
        case (r_state)
            BUSY_I: begin
                w_req.address     = i_address;
                w_req.read_enable = i_read_enable;
            end
            BUSY_D: begin
                w_req.address           = d_address;
                w_req.write_enable      = d_write_enable;
                w_req.read_enable       = d_read_enable && !d_write_enable;
                w_req.write_byte_enable = d_write_byte_enable;
                w_req.write_data        = d_write_data;
            end
            default: ;
        endcase
    end

    assign address           = w_req.address;
    assign read_enable       = w_req.read_enable;
    assign write_enable      = w_req.write_enable;
    assign write_byte_enable = w_req.write_byte_enable;
    assign write_data        = w_req.write_data;

    assign w_mem_ack   = (w_busy_i && read_ack)
                      || (w_busy_d && (d_write_enable ? write_ack : read_ack));
    assign w_withdraw  = (w_busy_i && !i_read_enable)
                      || (w_busy_d && !d_read_enable && !d_write_enable);
    assign w_wd_expire = !w_idle && w_wd_hit;
    assign w_owner_ack = w_mem_ack || w_wd_expire;

    assign i_read_ack  = w_busy_i && i_read_enable && w_owner_ack;
    assign d_write_ack = w_busy_d && d_write_enable && w_owner_ack;
    assign d_read_ack  = w_busy_d && d_read_enable && !d_write_enable && w_owner_ack;
    assign i_read_data = w_wd_expire ? 32'h0 : read_data;
    assign d_read_data = w_wd_expire ? 32'h0 : read_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_wd_expire && !w_mem_ack) begin
                r_timeout_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state <= BUSY_D;
                    end else if (w_grant_i) begin
                        r_state <= BUSY_I;
                    end
                end
                default: begin
                    if (w_owner_ack || w_withdraw) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign grant       = w_busy_i ? GRANT_I : (w_busy_d ? GRANT_D : GRANT_NONE);
    assign timeout_err = r_timeout_err;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single ssram port between the instruction-fetch unit (read-only, port I) and memory_ctrl (read/write, port D).
- Sits between both requesters and ssram, using the same level handshake that memory_ctrl and ssram already use: enable held until ack.
- Data requests have priority, with a starvation limit that guarantees fetch progress.
- A watchdog completes any access that never receives an ack.

Parameters:
- STARVE_LIMIT, 4: consecutive D grants allowed while I is waiting before I is forced.
- TIMEOUT, 64: cycles in a busy state without memory ack before the arbiter self-completes the access.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_address  in  32  fetch address.
- i_read_enable  in  1  fetch request.
- i_read_data  out  32  fetch data, valid with i_read_ack.
- i_read_ack  out  1  fetch completion.
- d_address  in  32  data address.
- d_read_enable  in  1  data read request.
- d_read_data  out  32  read data, valid with d_read_ack.
- d_read_ack  out  1  read completion.
- d_write_enable  in  1  data write request.
- d_write_byte_enable  in  4  byte lanes.
- d_write_data  in  32  write data.
- d_write_ack  out  1  write completion.
- address  out  32  to ssram.
- read_enable  out  1  to ssram.
- read_data  in  32  from ssram.
- read_ack  in  1  from ssram.
- write_enable  out  1  to ssram.
- write_byte_enable  out  4  to ssram.
- write_data  out  32  to ssram.
- write_ack  in  1  from ssram.
- grant  out  2  current owner: 00 idle, 01 I, 10 D.
- timeout_err  out  1  sticky; set on any watchdog expiry.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; starve and watchdog counters clear; timeout_err=0.
  - All ssram-side enables and all acks are 0; address, write_data and write_byte_enable are 0.
  - Reset mid-access abandons the access immediately; no ack is issued.
- FSM states: IDLE, BUSY_I, BUSY_D.
- ssram-side outputs are driven combinationally from the registered owner. In IDLE every enable is 0.
- Arbitration happens in IDLE only:
  - If D requests (read or write) and (I not requesting or starve_cnt < STARVE_LIMIT), go to BUSY_D.
  - Otherwise, if I requests, go to BUSY_I.
- Latency: a request visible in IDLE in cycle N drives the ssram enables in cycle N+1.
- D port with both enables high: write wins; read_enable is masked for that access.
- In a BUSY state, the matching ack is routed combinationally to the owner; the other requester sees ack=0.
  - read_data fans out to both i_read_data and d_read_data; it is meaningful only with ack.
  - An ack that arrives in the first busy cycle completes the access in that cycle.
- Ack, requester withdrawal (enable drops) or watchdog expiry causes a return to IDLE.
  - There is always at least one IDLE cycle between grants, so at most 1 access per 2 cycles.
- Starve counter:
  - Increments on each grant to D while i_read_enable=1.
  - Clears on a grant to I or whenever i_read_enable=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- Watchdog:
  - Counts cycles in a BUSY state and clears on entry.
  - On reaching TIMEOUT without ack, the arbiter asserts the owner's ack for one cycle with read data forced to 32'h0, sets timeout_err, and returns to IDLE.
- grant mirrors the state (IDLE=00, BUSY_I=01, BUSY_D=10).

Decomposition:
- Shared package mem_pkg holds:
  - typedef arb_state_t (IDLE, BUSY_I, BUSY_D);
  - typedef mem_req_t (address, read_enable, write_enable, write_byte_enable, write_data);
  - localparams GRANT_NONE / GRANT_I / GRANT_D.
- One sub-module, mem_arb_timer: a parameterised saturating counter with clear/enable/limit-hit, instantiated twice (starvation and watchdog).

Test Plan:
- Single fetch, i_address=32'h100, read_ack tied 1:
  - read_enable=1 with address=32'h100 one cycle after request;
  - i_read_ack=1 that cycle with i_read_data=read_data;
  - grant goes 00 to 01 to 00.
- D word write of 32'h12345678 to 32'h40 (byte enables 4'hF), then D read of 32'h40:
  - ssram sees write then read;
  - d_read_data=32'h12345678;
  - I never acked.
- I and D request continuously, acks tied 1:
  - grant sequence 10,10,10,10,01,10,10,10,10,01 (separated by idle cycles);
  - I is served every 5th grant.
- Simultaneous I and D request in the same IDLE cycle, with starve counter 0:
  - D is granted first;
  - I is granted next, after one idle cycle.
- Acks tied 0, D read issued:
  - after TIMEOUT=64 busy cycles, d_read_ack pulses once with d_read_data=0;
  - timeout_err=1 and stays 1 until rst is asserted.
- rst asserted while in BUSY_D with ack withheld:
  - all enables and acks drop asynchronously, and grant=00;
  - after release, a fresh I request completes normally.
